// File: rtl/nibble_arith_pkg.sv
// Shared types and helpers for the nibble-serial adder.
// Optional subtract mode is enabled with NIBBLE_SERIAL_SUB_EN.
package nibble_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int NIBBLE_W = 4;

    function automatic int idx_w(input int nibbles);
        return (nibbles <= 1) ? 1 : $clog2(nibbles);
    endfunction

endpackage

// File: rtl/nibble_add_slice.sv
// Combinational 4-bit ripple adder slice built from full adders.
module nibble_add_slice
    import nibble_arith_pkg::*;
(
    input  logic [NIBBLE_W-1:0] in_a,
    input  logic [NIBBLE_W-1:0] in_b,
    input  logic                in_ci,
    output logic [NIBBLE_W-1:0] out_s,
    output logic                out_co
);

    logic [NIBBLE_W:0] c;

    assign c[0] = in_ci;

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
        assign out_s[i] = in_a[i] ^ in_b[i] ^ c[i];
        assign c[i+1]   = (in_a[i] & in_b[i]) | (c[i] & (in_a[i] ^ in_b[i]));
    end

    assign out_co = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Wide add on one shared 4-bit slice, one nibble per clock, LS nibble first.
// Define NIBBLE_SERIAL_SUB_EN to add the in_sub port (A - B mode).
module nibble_serial_add_ctrl
    import nibble_arith_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                         in_clk,
    input  logic                         in_rst,
    input  logic                         in_start,
    input  logic [NIBBLE_W*NIBBLES-1:0]  in_A,
    input  logic [NIBBLE_W*NIBBLES-1:0]  in_B,
    input  logic                         in_C,
`ifdef NIBBLE_SERIAL_SUB_EN
    input  logic                         in_sub,
`endif
    output logic [NIBBLE_W*NIBBLES-1:0]  out_S,
    output logic                         out_C,
    output logic                         out_busy,
    output logic                         out_done
);

    localparam int W  = NIBBLE_W * NIBBLES;
    localparam int IW = idx_w(NIBBLES);
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    s_q, s_d;
    logic            c_q, c_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [NIBBLE_W-1:0] a_nib, b_nib, sum_nib;
    logic                co;

`ifdef NIBBLE_SERIAL_SUB_EN
    logic sub_q, sub_d;
`else
    logic sub_q;
    assign sub_q = 1'b0;
`endif

    // Operand nibble select; B is inverted in subtract mode
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IW'(i)) begin
                a_nib = a_q[i*NIBBLE_W +: NIBBLE_W];
                b_nib = b_q[i*NIBBLE_W +: NIBBLE_W];
            end
        end
        b_nib = b_nib ^ {NIBBLE_W{sub_q}};
    end

    nibble_add_slice u_slice (
        .in_a   (a_nib),
        .in_b   (b_nib),
        .in_ci  (carry_q),
        .out_s  (sum_nib),
        .out_co (co)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        c_d     = c_q;
`ifdef NIBBLE_SERIAL_SUB_EN
        sub_d   = sub_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                if (in_start) begin
                    a_d     = in_A;
                    b_d     = in_B;
                    idx_d   = '0;
                    state_d = RUN;
`ifdef NIBBLE_SERIAL_SUB_EN
                    sub_d   = in_sub;
                    carry_d = in_sub | in_C;
`else
                    carry_d = in_C;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                for (int i = 0; i < NIBBLES; i++) begin
                    if (idx_q == IW'(i)) begin
                        s_d[i*NIBBLE_W +: NIBBLE_W] = sum_nib;
                    end
                end
                carry_d = co;
                idx_d   = idx_q + IW'(1);
                if (idx_q == LAST) begin
                    c_d     = co;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef NIBBLE_SERIAL_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            c_q     <= c_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef NIBBLE_SERIAL_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

    assign out_S    = s_q;
    assign out_C    = c_q;
    assign out_busy = busy_q;
    assign out_done = done_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed plus random bench for nibble_serial_add_ctrl (NIBBLES = 4).
module tb_nibble_serial_add_ctrl;
    import nibble_arith_pkg::*;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_start;
    logic [W-1:0] in_A, in_B;
    logic         in_C;
    logic         in_sub;
    logic [W-1:0] out_S;
    logic         out_C, out_busy, out_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    nibble_serial_add_ctrl #(.NIBBLES(N)) dut (
        .in_clk   (clk),
        .in_rst   (rst),
        .in_start (in_start),
        .in_A     (in_A),
        .in_B     (in_B),
        .in_C     (in_C),
`ifdef NIBBLE_SERIAL_SUB_EN
        .in_sub   (in_sub),
`endif
        .out_S    (out_S),
        .out_C    (out_C),
        .out_busy (out_busy),
        .out_done (out_done)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic c, input logic s);
        if (s)
            return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        return {1'b0, a} + {1'b0, b} + (W+1)'(c);
    endfunction

    // One full operation; noise scrambles inputs while RUN is active
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input logic s, input logic noise);
        logic [W:0]   exp;
        logic [W-1:0] mask;
        exp      = model(a, b, c, s);
        in_A     = a;
        in_B     = b;
        in_C     = c;
        in_sub   = s;
        in_start = 1'b1;
        tick();
        in_start = 1'b0;
        for (int k = 0; k < N; k++) begin
            check("busy_run", 32'(out_busy), 32'd1);
            check("done_run", 32'(out_done), 32'd0);
            if (k > 0) begin
                mask = W'((64'd1 << (4 * k)) - 64'd1);
                check("partial", 32'(out_S & mask), 32'(exp[W-1:0] & mask));
            end
            if (noise) begin
                in_A     = W'($urandom);
                in_B     = W'($urandom);
                in_C     = 1'($urandom);
                in_sub   = 1'($urandom);
                in_start = 1'($urandom);
            end
            tick();
        end
        in_start = 1'b0;
        check("done", 32'(out_done), 32'd1);
        check("busy_done", 32'(out_busy), 32'd0);
        check("sum", 32'(out_S), 32'(exp[W-1:0]));
        check("carry", 32'(out_C), 32'(exp[W]));
        tick();
        check("done_clr", 32'(out_done), 32'd0);
        check("busy_idle", 32'(out_busy), 32'd0);
        check("sum_hold", 32'(out_S), 32'(exp[W-1:0]));
        check("carry_hold", 32'(out_C), 32'(exp[W]));
    endtask

    initial begin
        int n;
        rst      = 1'b1;
        in_start = 1'b1;
        in_A     = '1;
        in_B     = '1;
        in_C     = 1'b1;
        in_sub   = 1'b0;
        tick();
        tick();
        rst      = 1'b0;
        in_start = 1'b0;
        check("rst_S", 32'(out_S), 32'd0);
        check("rst_C", 32'(out_C), 32'd0);
        check("rst_busy", 32'(out_busy), 32'd0);
        check("rst_done", 32'(out_done), 32'd0);
        tick();

        run_op(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        run_op(16'hABCD, 16'h1111, 1'b0, 1'b0, 1'b1);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0);

        // Back-to-back with start held high
        in_A     = 16'h00F0;
        in_B     = 16'h0010;
        in_C     = 1'b1;
        in_start = 1'b1;
        tick();
        in_A = 16'h1234;
        in_B = 16'h4321;
        in_C = 1'b0;
        n = 0;
        while (!out_done && n < 20) begin
            tick();
            n++;
        end
        check("b2b_lat1", 32'(n), 32'd4);
        check("b2b_sum1", 32'(out_S), 32'h0101);
        check("b2b_c1", 32'(out_C), 32'd0);
        n = 0;
        do begin
            tick();
            n++;
        end while (!out_done && n < 20);
        check("b2b_gap", 32'(n), 32'd5);
        check("b2b_sum2", 32'(out_S), 32'h5555);
        check("b2b_c2", 32'(out_C), 32'd0);
        in_start = 1'b0;
        tick();
        check("b2b_idle_busy", 32'(out_busy), 32'd0);
        check("b2b_idle_done", 32'(out_done), 32'd0);

        // Reset in the middle of a run
        in_A     = 16'h7777;
        in_B     = 16'h7777;
        in_start = 1'b1;
        tick();
        in_start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_S", 32'(out_S), 32'd0);
        check("mid_rst_C", 32'(out_C), 32'd0);
        check("mid_rst_busy", 32'(out_busy), 32'd0);
        check("mid_rst_done", 32'(out_done), 32'd0);
        check("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
        run_op(16'h0F0F, 16'h0101, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++)
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0,
                   1'($urandom));

`ifdef NIBBLE_SERIAL_SUB_EN
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0);
        run_op(16'h0007, 16'h0005, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++)
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
